// File: rtl/fp_pkg.sv
// Shared constants, state encoding and helpers for the float
// normalize/round stage.
package fp_pkg;
    localparam int EXP_W  = 8;
    localparam int MANT_W = 28;

    localparam int CARRY_BIT  = 27;
    localparam int HIDDEN_BIT = 26;
    localparam int GUARD_BIT  = 2;
    localparam int ROUND_BIT  = 1;
    localparam int STICKY_BIT = 0;

    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
    localparam int BIAS = 127;

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        ROUND,
        OUT
    } state_t;

    // Leading zeros counted down from the hidden bit; 27 when all zero.
    function automatic logic [4:0] lzc27(input logic [26:0] m);
        logic [4:0] n;
        logic found;
        n = 5'd0;
        found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!found) begin
                if (m[i]) found = 1'b1;
                else n = n + 5'd1;
            end
        end
        return n;
    endfunction
endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on the extended mantissa; combinational.
// A carry out of the 24-bit significand renormalizes by one place.
module fp_round_rne
    import fp_pkg::*;
(
    input  logic [MANT_W-1:0] mantis,
    input  logic [EXP_W-1:0]  exp_in,
    output logic [23:0]       sig,
    output logic [EXP_W-1:0]  exp_out,
    output logic              overflow,
    output logic              inexact
);
    logic          rnd_up;
    logic [24:0]   sum;
    logic [EXP_W:0] e9;

    always_comb begin
        rnd_up = mantis[GUARD_BIT]
               & (mantis[ROUND_BIT] | mantis[STICKY_BIT]
                  | mantis[GUARD_BIT+1]);
        sum = mantis[CARRY_BIT:GUARD_BIT+1] + {24'd0, rnd_up};
        e9 = {1'b0, exp_in};
        sig = sum[23:0];
        if (sum[24]) begin
            sig = sum[24:1];
            e9 = e9 + 9'd1;
        end
        exp_out = e9[EXP_W-1:0];
        overflow = e9 >= {1'b0, EXP_MAX};
        inexact = |mantis[GUARD_BIT:STICKY_BIT];
    end
endmodule

// File: rtl/fp_norm_round.sv
// Normalize, round-to-nearest-even and pack a single-precision result.
// Define FP_NORM_FAST_EN for single-cycle LZC + barrel normalization.
module fp_norm_round
    import fp_pkg::*;
#(
    parameter int MAX_NORM_STEPS = 27
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [MANT_W-1:0] in_mantis,
    input  logic              in_loss,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_result,
    output logic              out_overflow,
    output logic              out_inexact
);
    state_t            state;
    logic              sign_q;
    logic [EXP_W-1:0]  exp_q;
    logic [MANT_W-1:0] man_q;
    logic              ovf_q;

    logic [23:0]      r_sig;
    logic [EXP_W-1:0] r_exp;
    logic [EXP_W-1:0] r_exp_f;
    logic             r_ovf;
    logic             r_inex;

    fp_round_rne u_round (
        .mantis   (man_q),
        .exp_in   (exp_q),
        .sig      (r_sig),
        .exp_out  (r_exp),
        .overflow (r_ovf),
        .inexact  (r_inex)
    );

    // A subnormal that rounds up into the hidden bit becomes normal.
    assign r_exp_f = r_exp
                   | {7'd0, r_sig[23] & (r_exp == 8'd0)};

`ifdef FP_NORM_FAST_EN
    logic [4:0]        lz;
    logic [EXP_W-1:0]  sh;
    logic [MANT_W-1:0] f_man;
    logic [EXP_W-1:0]  f_exp;

    always_comb begin
        lz = lzc27(man_q[HIDDEN_BIT:0]);
        if (exp_q <= 8'd1) sh = 8'd0;
        else if ({3'd0, lz} < exp_q) sh = {3'd0, lz};
        else sh = exp_q - 8'd1;
        f_man = man_q << sh;
        f_exp = exp_q - sh;
        if (!f_man[HIDDEN_BIT]) f_exp = 8'd0;
    end
`else
    localparam int CNT_W = $clog2(MAX_NORM_STEPS + 1);
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_nx;

    assign cnt_nx = cnt_q + CNT_W'(1);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            in_ready     <= 1'b1;
            out_valid    <= 1'b0;
            out_result   <= 32'd0;
            out_overflow <= 1'b0;
            out_inexact  <= 1'b0;
            sign_q       <= 1'b0;
            exp_q        <= '0;
            man_q        <= '0;
            ovf_q        <= 1'b0;
`ifndef FP_NORM_FAST_EN
            cnt_q        <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign_q   <= in_sign;
                        exp_q    <= in_exp;
                        man_q    <= {in_mantis[MANT_W-1:1],
                                     in_mantis[STICKY_BIT] | in_loss};
                        ovf_q    <= in_exp == EXP_MAX;
                        in_ready <= 1'b0;
                        state    <= NORM;
`ifndef FP_NORM_FAST_EN
                        cnt_q    <= '0;
`endif
                    end
                end
                NORM: begin
                    if (ovf_q) begin
                        state <= ROUND;
                    end else if (man_q == '0) begin
`ifdef FP_NORM_FAST_EN
                        exp_q <= '0;
                        state <= ROUND;
`else
                        out_result   <= {sign_q, 31'd0};
                        out_overflow <= 1'b0;
                        out_inexact  <= 1'b0;
                        out_valid    <= 1'b1;
                        state        <= OUT;
`endif
                    end else if (man_q[CARRY_BIT]) begin
                        man_q <= {1'b0, man_q[CARRY_BIT:GUARD_BIT],
                                  man_q[ROUND_BIT] | man_q[STICKY_BIT]};
                        exp_q <= exp_q + 8'd1;
                        state <= ROUND;
`ifdef FP_NORM_FAST_EN
                    end else begin
                        man_q <= f_man;
                        exp_q <= f_exp;
                        state <= ROUND;
                    end
`else
                    end else if (man_q[HIDDEN_BIT]) begin
                        state <= ROUND;
                    end else if (exp_q <= 8'd1) begin
                        exp_q <= '0;
                        state <= ROUND;
                    end else begin
                        man_q <= man_q << 1;
                        exp_q <= exp_q - 8'd1;
                        cnt_q <= cnt_nx;
                        if (cnt_nx == CNT_W'(MAX_NORM_STEPS))
                            state <= ROUND;
                    end
`endif
                end
                ROUND: begin
                    if (ovf_q || r_ovf) begin
                        out_result   <= {sign_q, EXP_MAX, 23'd0};
                        out_overflow <= 1'b1;
                    end else begin
                        out_result   <= {sign_q, r_exp_f, r_sig[22:0]};
                        out_overflow <= 1'b0;
                    end
                    out_inexact <= r_inex;
                    out_valid   <= 1'b1;
                    state       <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_norm_round.sv
// Directed bench for fp_norm_round with a value-level reference model.
// Covers rounding, overflow, subnormals, backpressure and reset.
module tb_fp_norm_round;
    import fp_pkg::*;

`ifdef FP_NORM_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif
    localparam logic [7:0] E1 = 8'(BIAS);

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [7:0]  in_exp = 8'd0;
    logic [27:0] in_mantis = 28'd0;
    logic        in_loss = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic        out_overflow;
    logic        out_inexact;

    fp_norm_round dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sign      (in_sign),
        .in_exp       (in_exp),
        .in_mantis    (in_mantis),
        .in_loss      (in_loss),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_overflow (out_overflow),
        .out_inexact  (out_inexact)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        logic        inex;
    } exp_t;
    exp_t q[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Value-level reference: normalize, RNE, pack.
    function automatic void model(input logic s, input logic [7:0] e_in,
                                  input logic [27:0] m_in,
                                  output logic [31:0] res,
                                  output logic ovf, output logic inex,
                                  output int lat);
        int e;
        int k;
        longint m;
        longint sig;
        longint rem;
        e = int'(e_in);
        m = longint'(m_in);
        k = 0;
        ovf = 1'b0;
        lat = 3;
        if (e == 255) begin
            res = {s, 8'hFF, 23'd0};
            ovf = 1'b1;
            inex = (m % 8) != 0;
            return;
        end
        if (m == 0) begin
            res = {s, 31'd0};
            inex = 1'b0;
            lat = FAST ? 3 : 2;
            return;
        end
        if (m >= 2**27) begin
            m = (m >> 1) | (m & 1);
            e++;
        end else begin
            while (m < 2**26 && e > 1) begin
                m = m * 2;
                e--;
                k++;
            end
            if (m < 2**26) e = 0;
        end
        lat = FAST ? 3 : 3 + k;
        sig = m >> 3;
        rem = m % 8;
        inex = rem != 0;
        if (rem > 4 || (rem == 4 && (sig % 2) == 1)) sig = sig + 1;
        if (sig == 2**24) begin
            sig = sig / 2;
            e++;
        end
        if (e == 0 && sig >= 2**23) e = 1;
        if (e >= 255) begin
            res = {s, 8'hFF, 23'd0};
            ovf = 1'b1;
        end else begin
            res = {s, 8'(e), 23'(sig)};
        end
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (q.size() == 0) begin
                checks++;
                errs++;
                $display("FAIL unexpected_valid: got %h want none",
                         out_result);
            end else begin
                chk("result", out_result, q[0].res);
                chk("overflow", 32'(out_overflow), 32'(q[0].ovf));
                chk("inexact", 32'(out_inexact), 32'(q[0].inex));
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    task automatic launch(input logic s, input logic [7:0] e,
                          input logic [27:0] m, input logic loss);
        bit acc;
        int n;
        in_valid = 1'b1;
        in_sign = s;
        in_exp = e;
        in_mantis = m;
        in_loss = loss;
        n = 0;
        do begin
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 50);
        if (!acc) begin
            checks++;
            errs++;
            $display("FAIL accept_timeout: got %0d cycles want <50", n);
        end
        in_valid = 1'b0;
        in_loss = 1'b0;
    endtask

    task automatic op(input logic s, input logic [7:0] e,
                      input logic [27:0] m, input logic loss,
                      input logic [31:0] lit, input logic lit_o,
                      input logic lit_x, input int hold);
        logic [31:0] r;
        logic o;
        logic x;
        int lat;
        int n;
        model(s, e, loss ? (m | 28'd1) : m, r, o, x, lat);
        chk("model_pin", r, lit);
        chk("model_ovf_pin", 32'(o), 32'(lit_o));
        chk("model_inex_pin", 32'(x), 32'(lit_x));
        q.push_back('{r, o, x});
        out_ready = (hold == 0);
        launch(s, e, m, loss);
        n = 1;
        while (!out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency", n, lat);
        repeat (hold) begin
            @(posedge clk);
            #1;
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("valid_drop", 32'(out_valid), 32'd0);
        chk("ready_back", 32'(in_ready), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", out_result, 32'd0);
        chk("rst_ovf", 32'(out_overflow), 32'd0);
        chk("rst_inex", 32'(out_inexact), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        op(0, E1, 28'h4000000, 0, 32'h3F800000, 0, 0, 0);
        op(0, E1, 28'h8000000, 0, 32'h40000000, 0, 0, 0);
        op(0, E1, 28'h0800000, 0, 32'h3E000000, 0, 0, 0);
        op(0, E1, 28'h4000004, 0, 32'h3F800000, 0, 1, 0);
        op(0, E1, 28'h400000C, 0, 32'h3F800002, 0, 1, 0);
        op(0, E1, 28'h4000000, 1, 32'h3F800000, 0, 1, 0);
        op(1, 8'd254, 28'h8000000, 0, 32'hFF800000, 1, 0, 0);
        op(1, E1, 28'h0000000, 0, 32'h80000000, 0, 0, 0);
        op(0, E1, 28'h4000000, 0, 32'h3F800000, 0, 0, 5);
        op(0, E1, 28'h7FFFFFC, 0, 32'h40000000, 0, 1, 0);
        op(0, 8'd254, 28'h7FFFFFC, 0, 32'h7F800000, 1, 1, 0);
        op(0, 8'd255, 28'h4000000, 0, 32'h7F800000, 1, 0, 0);
        op(0, 8'd3, 28'h0100000, 0, 32'h00080000, 0, 0, 0);
        op(0, 8'd1, 28'h2000000, 0, 32'h00400000, 0, 0, 0);
        op(0, 8'd1, 28'h3FFFFFC, 0, 32'h00800000, 0, 1, 0);
        op(0, E1, 28'h8000006, 0, 32'h40000000, 0, 1, 0);
        op(1, 8'd150, 28'h0000001, 0, 32'hBE000000, 0, 0, 0);

        launch(0, E1, 28'h0000100, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        repeat (30) @(posedge clk);
        #1;
        op(0, E1, 28'h0800000, 0, 32'h3E000000, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/fp_norm_round.md
Name: fp_norm_round

Overview:
- Post-add/subtract stage of the float datapath; sits directly downstream of the alignment shifter and mantissa adder.
- Consumes the 28-bit extended mantissa, 8-bit exponent, sign and shifter loss/sticky flag.
- Normalizes iteratively, rounds to nearest-even, and packs an IEEE-754 single-precision word.
- Valid/ready handshake on both sides; one operation in flight.

Parameters:
- MAX_NORM_STEPS, 27, upper bound on left-normalize iterations; a counter aborts at this limit as a safety net.

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand valid
- in_ready  out  1  stage can accept; high only in IDLE
- in_sign  in  1  result sign
- in_exp  in  8  biased exponent
- in_mantis  in  28  [27]=carry, [26]=hidden, [25:3]=fraction, [2]=guard, [1]=round, [0]=sticky
- in_loss  in  1  bits lost by the upstream shifter; ORed into sticky
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_result  out  32  {sign, exp[7:0], frac[22:0]}
- out_overflow  out  1  result rounded to infinity
- out_inexact  out  1  any of G/R/S nonzero before rounding

Behaviour:
- Reset (synchronous, active-high): state=IDLE, in_ready=1, out_valid=0, out_result=0, out_overflow=0, out_inexact=0, step counter=0. Reset mid-operation discards the operation; no output is produced for it.
- IDLE: on in_valid&&in_ready, capture sign, exp, mantis with mantis[0] |= in_loss; go to NORM.
- NORM, one action per cycle, in priority order:
  - mantis==0 → zero result (sign kept, exp=0, frac=0); go to OUT.
  - mantis[27]=1 → shift right 1, new sticky = old[1]|old[0]; exp+1; go to ROUND.
  - mantis[26]=1 → go to ROUND.
  - exp<=1 → denormal: exp field becomes 0; go to ROUND.
  - Otherwise → shift left 1, exp-1, counter+1. If counter reaches MAX_NORM_STEPS, go to ROUND.
- ROUND (1 cycle): round_up = G & (R | S | frac_lsb).
  - Add round_up to {hidden, frac}. On carry out of 24 bits, shift right 1 and exp+1.
  - If exp==255 after normalize or round → infinity {sign, 8'hFF, 0}, overflow=1.
  - inexact = G|R|S.
  - Go to OUT.
- OUT: out_valid=1; outputs stable until out_ready. On out_valid&&out_ready → IDLE, out_valid=0 next cycle. Back-to-back acceptance resumes the following cycle.
- Input exp==255 is treated as overflow → infinity.
- Latency from accept to out_valid:
  - 3 cycles for an already-normalized or carry input.
  - 3+k cycles for k left shifts.
- Throughput: one operation per (latency+1) cycles minimum.

Optional Feature:
- FP_NORM_FAST_EN defined: NORM is replaced by a single-cycle leading-zero count plus barrel shift (clamped so exp stays >=1). Latency is fixed at 3 cycles for every input. Results are bit-identical to the iterative path.
- Undefined: iterative 1-bit-per-cycle normalization as described under Behaviour.

Decomposition:
- Shared package fp_pkg holds:
  - EXP_W=8, MANT_W=28
  - bit-position constants CARRY_BIT=27, HIDDEN_BIT=26, GUARD_BIT=2, ROUND_BIT=1, STICKY_BIT=0
  - EXP_MAX=8'hFF, BIAS=127
  - state enum {IDLE, NORM, ROUND, OUT}
- One sub-module: fp_round_rne, combinational. Takes 28-bit mantissa and exp; returns rounded 24-bit significand, exp, overflow, inexact.

Test Plan:
- exp=127, mantis=28'h4000000, sign=0 → out_result=32'h3F800000, out_valid 3 cycles after accept, inexact=0.
- exp=127, mantis=28'h8000000 (carry) → 32'h40000000. Then exp=127, mantis=28'h0800000 → three left shifts, 32'h3E000000 after 6 cycles (3 with FP_NORM_FAST_EN).
- Rounding:
  - mantis=28'h4000004 (tie, lsb 0) → 32'h3F800000, inexact=1.
  - mantis=28'h400000C (tie, lsb 1) → 32'h3F800002.
  - mantis=28'h4000000 with in_loss=1 → 32'h3F800000, inexact=1.
- exp=254, mantis=28'h8000000, sign=1 → 32'hFF800000, out_overflow=1. Mantis=0, sign=1 → 32'h80000000.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles in OUT → out_result stable, in_ready=0.
  - Assert rst during NORM → next cycle IDLE, out_valid=0, in_ready=1; a fresh operation completes correctly.
